mms_stream: RTL and testbench



---
 rtl/mms_stream.sv | 103 ++++++++++
 tb/tb_mms_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mms_stream.sv
// Streaming max/min selector over fixed-size frames.
// Accepts N_NUM numbers serially and hands back the winner and its position.
module mms_stream #(
  parameter int WIDTH  = 8,
  parameter int N_NUM  = 8,
  parameter int SIGNED = 0,
  parameter int IDX_W  = $clog2(N_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [IDX_W-1:0] index,
  output logic             mode
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] count;
  logic             accept;
  logic             gt;
  logic             lt;
  logic             repl;
  logic             last;

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt = $signed(number) > $signed(best);
      assign lt = $signed(number) < $signed(best);
    end else begin : g_unsigned
      assign gt = number > best;
      assign lt = number < best;
    end
  endgenerate

  // strict compare: ties keep the earlier element
  assign repl = mode ? lt : gt;
  assign last = (count == IDX_W'(N_NUM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      index     <= '0;
      mode      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            best     <= number;
            best_idx <= '0;
            mode     <= select;
            count    <= IDX_W'(1);
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count + IDX_W'(1);
            if (repl) begin
              best     <= number;
              best_idx <= count;
            end
            if (last) begin
              result    <= repl ? number : best;
              index     <= repl ? count : best_idx;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mms_stream.sv
// Bench for mms_stream: three configurations, randomized frames
// checked against an array-based max/min reference.
module tb_mms_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [15:0] num;
  logic [2:0]  iv;
  logic [2:0]  ordy;

  always #5 clk = ~clk;

  logic       ir0, ov0, md0;
  logic [7:0] res0;
  logic [2:0] idx0;
  logic       ir1, ov1, md1;
  logic [7:0] res1;
  logic [2:0] idx1;
  logic        ir2, ov2, md2;
  logic [15:0] res2;
  logic [0:0]  idx2;

  mms_stream #(.WIDTH(8), .N_NUM(8), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .select(sel),
    .in_valid(iv[0]), .in_ready(ir0), .number(num[7:0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .result(res0), .index(idx0), .mode(md0)
  );

  mms_stream #(.WIDTH(8), .N_NUM(8), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .select(sel),
    .in_valid(iv[1]), .in_ready(ir1), .number(num[7:0]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .result(res1), .index(idx1), .mode(md1)
  );

  mms_stream #(.WIDTH(16), .N_NUM(2), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .select(sel),
    .in_valid(iv[2]), .in_ready(ir2), .number(num),
    .out_valid(ov2), .out_ready(ordy[2]),
    .result(res2), .index(idx2), .mode(md2)
  );

  int          k;
  logic        cir, cov, cmd;
  logic [15:0] cres;
  logic [9:0]  cidx;

  always_comb begin
    cir  = ir0;
    cov  = ov0;
    cmd  = md0;
    cres = {8'h00, res0};
    cidx = {7'd0, idx0};
    case (k)
      1: begin
        cir  = ir1;
        cov  = ov1;
        cmd  = md1;
        cres = {8'h00, res1};
        cidx = {7'd0, idx1};
      end
      2: begin
        cir  = ir2;
        cov  = ov2;
        cmd  = md2;
        cres = res2;
        cidx = {9'd0, idx2};
      end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wd(int kk);
    return (kk == 2) ? 16 : 8;
  endfunction

  function automatic int nn(int kk);
    return (kk == 2) ? 2 : 8;
  endfunction

  function automatic int sg(int kk);
    return (kk == 1) ? 1 : 0;
  endfunction

  // Winner = extreme value by numeric meaning, earliest position on ties
  function automatic void model(int kk, int vals[$], bit s,
                                output int r, output int ix);
    int w, v, bv;
    w  = wd(kk);
    ix = 0;
    bv = 0;
    for (int i = 0; i < vals.size(); i++) begin
      v = vals[i];
      if (sg(kk) == 1 && ((v >> (w - 1)) & 1) == 1) v = v - (1 << w);
      if (i == 0 || (!s && v > bv) || (s && v < bv)) begin
        bv = v;
        ix = i;
      end
    end
    r = vals[ix];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame(int kk, int vals[$], bit s, int gap,
                           int hold, int toggle_at);
    int r, ix, n;
    k = kk;
    n = vals.size();
    model(kk, vals, s, r, ix);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iv[kk] = 1'b1;
      num    = 16'(vals[i]);
      sel    = (toggle_at >= 0 && i > toggle_at) ? ~s : s;
      check("in_ready", int'(cir), 1);
      if (i == n - 1) check("ov_early", int'(cov), 0);
      @(posedge clk);
      if (gap > 0) begin
        @(negedge clk);
        iv[kk] = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    iv[kk] = 1'b0;
    check("out_valid", int'(cov), 1);
    check("result", int'(cres), r);
    check("index", int'(cidx), ix);
    check("mode", int'(cmd), int'(s));
    check("rdy_done", int'(cir), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ov", int'(cov), 1);
      check("hold_res", int'(cres), r);
      check("hold_idx", int'(cidx), ix);
      check("hold_mode", int'(cmd), int'(s));
      check("hold_rdy", int'(cir), 0);
    end
    ordy[kk] = 1'b1;
    @(negedge clk);
    ordy[kk] = 1'b0;
    check("xfer_ov", int'(cov), 0);
    check("xfer_rdy", int'(cir), 1);
  endtask

  initial begin
    int vals[$];
    int r, ix, last, nres, nfr;
    int pend[$];
    int er[$];
    int ei[$];
    int em[$];
    bit fs;

    k    = 0;
    rst  = 1'b0;
    sel  = 1'b0;
    num  = '0;
    iv   = '0;
    ordy = '0;
    do_reset();

    @(negedge clk);
    check("rst_ov", int'(cov), 0);
    check("rst_res", int'(cres), 0);
    check("rst_idx", int'(cidx), 0);
    check("rst_mode", int'(cmd), 0);
    check("rst_rdy", int'(cir), 1);

    vals = '{3, 17, 200, 5, 200, 0, 99, 1};
    run_frame(0, vals, 1'b0, 0, 0, -1);

    vals = '{9, 4, 4, 250, 7, 4, 8, 6};
    run_frame(0, vals, 1'b1, 1, 3, -1);

    vals = '{'h80, 'hFF, 'h7F, 'h00, 'h01, 'hFE, 'h10, 'h81};
    run_frame(1, vals, 1'b0, 0, 0, -1);
    run_frame(1, vals, 1'b1, 0, 1, -1);

    vals = '{10, 50, 30, 60, 20, 90, 5, 70};
    run_frame(0, vals, 1'b0, 0, 0, 1);

    // partial frame then reset
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      num   = 16'($urandom_range(0, 255));
      sel   = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ov", int'(cov), 0);
    check("mid_rst_res", int'(cres), 0);
    check("mid_rst_idx", int'(cidx), 0);
    check("mid_rst_rdy", int'(cir), 1);
    vals = '{7, 7, 1, 2, 3, 250, 4, 5};
    run_frame(0, vals, 1'b0, 0, 0, -1);

    for (int t = 0; t < 12; t++) begin
      int kk;
      kk = t % 3;
      vals.delete();
      for (int i = 0; i < nn(kk); i++)
        vals.push_back(int'($urandom_range(0, (1 << wd(kk)) - 1)));
      run_frame(kk, vals, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)) - 1);
    end

    vals = '{'hFFFF, 'hFFFF};
    run_frame(2, vals, 1'b1, 0, 0, -1);

    // back-to-back N_NUM=2 frames with permanent out_ready
    k       = 2;
    ordy[2] = 1'b1;
    last    = -1;
    nres    = 0;
    nfr     = 0;
    fs      = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cov) begin
        if (er.size() == 0) begin
          check("b2b_extra", nres, nfr);
        end else begin
          check("b2b_res", int'(cres), er.pop_front());
          check("b2b_idx", int'(cidx), ei.pop_front());
          check("b2b_mode", int'(cmd), em.pop_front());
        end
        if (last >= 0) check("b2b_gap", cyc - last, 3);
        last = cyc;
        nres++;
      end
      if (cir) begin
        if (pend.size() == 0) fs = 1'($urandom_range(0, 1));
        iv[2] = 1'b1;
        sel   = fs;
        num   = 16'($urandom_range(0, 65535));
        pend.push_back(int'(num));
        if (pend.size() == 2) begin
          model(2, pend, fs, r, ix);
          er.push_back(r);
          ei.push_back(ix);
          em.push_back(int'(fs));
          pend.delete();
          nfr++;
        end
      end else begin
        iv[2] = 1'b0;
      end
    end
    @(negedge clk);
    iv[2] = 1'b0;
    if (cov) begin
      if (er.size() > 0) begin
        check("b2b_res", int'(cres), er.pop_front());
        void'(ei.pop_front());
        void'(em.pop_front());
      end
      nres++;
    end
    ordy[2] = 1'b0;
    check("b2b_count", nres, nfr);
    check("b2b_rate", int'(nres >= 19), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", total);
    $fatal(1, "timeout");
  end

endmodule
